// File: rtl/lin_classifier.sv
// Line brightness classifier.
//
// Counts active pixels and dark pixels over each video line (delimited by the
// rising edge of hs_i). At every line boundary the finished line is judged dark
// when dark_cnt / tot_cnt >= NUM / DEN. The per-line verdict feeds a hysteresis
// filter that only flips rx_o after HYST consecutive disagreeing lines.
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_ni       asynchronous active-low reset
//   freeze_i     high at a boundary: the ending line is not evaluated
//   hs_i         horizontal sync, rising edge marks a line boundary
//   de_i         data enable, pixel valid when high
//   wd_i         pixel luma, WIDTH bits
//   line_dark_o  registered verdict of the last evaluated line
//   upd_o        one-cycle pulse whenever line_dark_o / rx_o are updated
//   rx_o         hysteresis-filtered dark verdict
module lin_classifier #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_PIX = 2048,
  parameter int unsigned DARK_TH = 64,
  parameter int unsigned NUM     = 1,
  parameter int unsigned DEN     = 2,
  parameter int unsigned HYST    = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             freeze_i,
  input  logic             hs_i,
  input  logic             de_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic             line_dark_o,
  output logic             upd_o,
  output logic             rx_o
);

  localparam int unsigned CW = $clog2(MAX_PIX + 1);
  localparam int unsigned MW = (NUM > DEN) ? NUM : DEN;
  localparam int unsigned PW = CW + $clog2(MW + 1);
  localparam int unsigned SW = $clog2(HYST + 1);

  localparam logic [CW-1:0]  MaxPix = CW'(MAX_PIX);
  // One extra bit so DARK_TH == 2**WIDTH (every pixel dark) is representable.
  localparam logic [WIDTH:0] DarkTh = (WIDTH + 1)'(DARK_TH);
  localparam logic [PW-1:0]  NumP   = PW'(NUM);
  localparam logic [PW-1:0]  DenP   = PW'(DEN);
  localparam logic [SW:0]    HystW  = (SW + 1)'(HYST);

  // Parameter sanity checks at elaboration.
  if (DEN < 1) begin : g_bad_den
    $error("lin_classifier: DEN must be >= 1");
  end
  if (NUM > DEN) begin : g_bad_num
    $error("lin_classifier: NUM must not exceed DEN");
  end
  if (HYST < 1) begin : g_bad_hyst
    $error("lin_classifier: HYST must be >= 1");
  end
  if (MAX_PIX < 1) begin : g_bad_max
    $error("lin_classifier: MAX_PIX must be >= 1");
  end
  if (64'(DARK_TH) > (64'd1 << WIDTH)) begin : g_bad_th
    $error("lin_classifier: DARK_TH must not exceed 2**WIDTH");
  end

  logic          hs_r_q, hs_r_d;
  logic          arm_q;
  logic [CW-1:0] tot_q, tot_d;
  logic [CW-1:0] dark_q, dark_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          line_dark_q, line_dark_d;
  logic          upd_q, upd_d;
  logic          rx_q, rx_d;

  logic          boundary;
  logic          dark_pix;
  logic          tot_sat;
  logic          eval_en;
  logic          verdict;
  logic [PW-1:0] dark_prod;
  logic [PW-1:0] tot_prod;
  logic [SW:0]   streak_inc;

  // arm_q keeps a high hs_i at reset release from looking like a rising edge:
  // a boundary is only recognised once hs_r_q has sampled hs_i at least once.
  assign boundary = hs_i & ~hs_r_q & arm_q;
  assign dark_pix = ({1'b0, wd_i} < DarkTh);
  assign tot_sat  = (tot_q == MaxPix);

  // Cross-multiplied ratio test on the pre-boundary counts; PW is wide enough
  // that neither product can overflow.
  assign dark_prod  = PW'(dark_q) * DenP;
  assign tot_prod   = PW'(tot_q) * NumP;
  assign verdict    = (dark_prod >= tot_prod);
  assign eval_en    = boundary & ~freeze_i & (tot_q != '0);
  assign streak_inc = {1'b0, streak_q} + (SW + 1)'(1);

  always_comb begin
    hs_r_d = hs_i;
    tot_d  = tot_q;
    dark_d = dark_q;

    if (boundary) begin
      // The boundary cycle's own pixel (if any) opens the new line.
      tot_d  = CW'(de_i);
      dark_d = CW'(de_i & dark_pix);
    end else if (de_i && !tot_sat) begin
      // Once tot saturates no further pixel is counted at all, so dark_cnt
      // can never overtake tot_cnt.
      tot_d = tot_q + CW'(1);
      if (dark_pix) begin
        dark_d = dark_q + CW'(1);
      end
    end
  end

  always_comb begin
    line_dark_d = line_dark_q;
    rx_d        = rx_q;
    streak_d    = streak_q;
    upd_d       = 1'b0;

    if (eval_en) begin
      upd_d       = 1'b1;
      line_dark_d = verdict;
      if (verdict == rx_q) begin
        streak_d = '0;
      end else if (streak_inc == HystW) begin
        rx_d     = verdict;
        streak_d = '0;
      end else begin
        streak_d = streak_inc[SW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_r_q      <= 1'b0;
      arm_q       <= 1'b0;
      tot_q       <= '0;
      dark_q      <= '0;
      streak_q    <= '0;
      line_dark_q <= 1'b0;
      upd_q       <= 1'b0;
      rx_q        <= 1'b0;
    end else begin
      hs_r_q      <= hs_r_d;
      arm_q       <= 1'b1;
      tot_q       <= tot_d;
      dark_q      <= dark_d;
      streak_q    <= streak_d;
      line_dark_q <= line_dark_d;
      upd_q       <= upd_d;
      rx_q        <= rx_d;
    end
  end

  assign line_dark_o = line_dark_q;
  assign upd_o       = upd_q;
  assign rx_o        = rx_q;

endmodule
